// File: rtl/urv_pipe_ctrl.sv
// Pipeline control: stall propagation, branch kill shadow, halt/drain FSM
// and saturating performance counters.
module urv_pipe_ctrl #(
  parameter int unsigned             g_num_stages      = 4,
  parameter int unsigned             g_branch_stage    = 2,
  parameter logic [g_num_stages-1:0] g_self_stall_mask = 4'b1010,
  parameter int unsigned             g_counter_width   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [g_num_stages-1:0]    stall_req_i,
  input  logic [g_num_stages-1:0]    valid_i,
  input  logic                       bra_i,
  input  logic                       halt_req_i,
  input  logic                       resume_i,
  input  logic                       perf_clr_i,
  output logic [g_num_stages-1:0]    stall_o,
  output logic [g_num_stages-1:0]    kill_o,
  output logic                       fetch_hold_o,
  output logic                       halted_o,
  output logic [g_counter_width-1:0] stall_cnt_o,
  output logic [g_counter_width-1:0] kill_cnt_o
);

  localparam int unsigned LP_N = g_num_stages;
  localparam int unsigned LP_B = g_branch_stage;
  localparam int unsigned LP_W = g_counter_width;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_fetch_hold;
  logic            r_halted;
  logic            w_next_fetch_hold;
  logic            w_next_halted;
  logic [LP_B-1:0] r_bh;
  logic [LP_W-1:0] r_stall_cnt;
  logic [LP_W-1:0] r_kill_cnt;
  logic [LP_N-1:0] w_stall;
  logic [LP_N-1:0] w_kill;
  logic            w_drained;

  // A stage stalls for any later request, and for its own unless it absorbs it.
  for (genvar s = 0; s < LP_N; s++) begin : g_stall
    logic w_upper;
    if (s == LP_N - 1) begin : g_last
      assign w_upper = 1'b0;
    end else begin : g_mid
      assign w_upper = |stall_req_i[LP_N-1:s+1];
    end
    if (s == 0) begin : g_fetch
      assign w_stall[s] = w_upper | (stall_req_i[s] & ~g_self_stall_mask[s]) | r_fetch_hold;
    end else begin : g_other
      assign w_stall[s] = w_upper | (stall_req_i[s] & ~g_self_stall_mask[s]);
    end
  end

  // Stage s up to the branch stage is killed if the branch or any shadowed one hits it.
  for (genvar s = 0; s < LP_N; s++) begin : g_kill
    if (s == 0) begin : g_first
      assign w_kill[s] = bra_i;
    end else if (s <= LP_B) begin : g_shadow
      assign w_kill[s] = bra_i | (|r_bh[s-1:0]);
    end else begin : g_beyond
      assign w_kill[s] = 1'b0;
    end
  end

  // Fetch (stage 0) does not count towards the drain condition.
  assign w_drained = ((valid_i & ~LP_N'(1)) == '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:    if (halt_req_i) w_next_state = ST_DRAIN;
      ST_DRAIN:  if (w_drained)  w_next_state = ST_HALTED;
      ST_HALTED: if (resume_i)   w_next_state = ST_RUN;
      default:                   w_next_state = ST_RUN;
    endcase
    w_next_fetch_hold = (w_next_state != ST_RUN);
    w_next_halted     = (w_next_state == ST_HALTED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_RUN;
      r_fetch_hold <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_fetch_hold <= w_next_fetch_hold;
      r_halted     <= w_next_halted;
    end
  end

  // Branch history advances only when the branch stage itself moves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bh <= '0;
    end else if (!w_stall[LP_B]) begin
      r_bh <= LP_B'({r_bh, bra_i});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr_i) begin
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if ((r_state == ST_RUN) && w_stall[0] && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + LP_W'(1);
      end
      if (bra_i && (r_kill_cnt != '1)) begin
        r_kill_cnt <= r_kill_cnt + LP_W'(1);
      end
    end
  end

  assign stall_o      = w_stall;
  assign kill_o       = w_kill;
  assign fetch_hold_o = r_fetch_hold;
  assign halted_o     = r_halted;
  assign stall_cnt_o  = r_stall_cnt;
  assign kill_cnt_o   = r_kill_cnt;

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Self-checking bench for urv_pipe_ctrl: directed scenarios then random stimulus
// against a behavioural model of the pipeline-control rules.
module tb_urv_pipe_ctrl;

  localparam int N = 4;
  localparam int B = 2;
  localparam int MAX = 255;
  localparam logic [3:0] MASK = 4'b1010;
  localparam int ST_RUN = 0;
  localparam int ST_DRAIN = 1;
  localparam int ST_HALTED = 2;

  logic       clk = 1'b0;
  logic       rst_i, bra_i, halt_req_i, resume_i, perf_clr_i;
  logic [3:0] stall_req_i, valid_i;
  logic [3:0] stall_o, kill_o;
  logic       fetch_hold_o, halted_o;
  logic [7:0] stall_cnt_o, kill_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_st = ST_RUN;
  logic [1:0] m_hist = 2'b00;
  int         m_sc = 0;
  int         m_kc = 0;

  always #5 clk = ~clk;

  urv_pipe_ctrl #(
    .g_num_stages(4), .g_branch_stage(2),
    .g_self_stall_mask(4'b1010), .g_counter_width(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_req_i(stall_req_i), .valid_i(valid_i),
    .bra_i(bra_i), .halt_req_i(halt_req_i), .resume_i(resume_i), .perf_clr_i(perf_clr_i),
    .stall_o(stall_o), .kill_o(kill_o), .fetch_hold_o(fetch_hold_o), .halted_o(halted_o),
    .stall_cnt_o(stall_cnt_o), .kill_cnt_o(kill_cnt_o)
  );

  function automatic logic [3:0] f_stall(input logic [3:0] req, input logic hold);
    logic [3:0] r;
    r = '0;
    for (int s = 0; s < N; s++) begin
      for (int j = s + 1; j < N; j++) r[s] = r[s] | req[j];
      if (!MASK[s]) r[s] = r[s] | req[s];
    end
    r[0] = r[0] | hold;
    return r;
  endfunction

  function automatic logic [3:0] f_kill(input logic br, input logic [1:0] hist);
    logic [3:0] r;
    r = '0;
    r[0] = br;
    for (int s = 1; s <= B; s++) begin
      r[s] = br;
      for (int k = 0; k < s; k++) r[s] = r[s] | hist[k];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic [3:0] req, input logic [3:0] vld,
                       input logic br, input logic hlt, input logic res, input logic clr);
    @(negedge clk);
    rst_i = rst; stall_req_i = req; valid_i = vld; bra_i = br;
    halt_req_i = hlt; resume_i = res; perf_clr_i = clr;
    #1;
    chk("stall_o", 32'(stall_o), 32'(f_stall(req, m_st != ST_RUN)));
    chk("kill_o", 32'(kill_o), 32'(f_kill(br, m_hist)));
    chk("fetch_hold_o", 32'(fetch_hold_o), 32'(m_st != ST_RUN));
    chk("halted_o", 32'(halted_o), 32'(m_st == ST_HALTED));
    chk("stall_cnt_o", 32'(stall_cnt_o), 32'(m_sc));
    chk("kill_cnt_o", 32'(kill_cnt_o), 32'(m_kc));
  endtask

  task automatic tick();
    logic [3:0] s;
    s = f_stall(stall_req_i, m_st != ST_RUN);
    @(posedge clk);
    if (rst_i) begin
      m_st = ST_RUN; m_hist = 2'b00; m_sc = 0; m_kc = 0;
    end else begin
      if (perf_clr_i) begin
        m_sc = 0; m_kc = 0;
      end else begin
        if (m_st == ST_RUN && s[0] && m_sc < MAX) m_sc++;
        if (bra_i && m_kc < MAX) m_kc++;
      end
      if (!s[B]) m_hist = {m_hist[0], bra_i};
      if (m_st == ST_RUN && halt_req_i) m_st = ST_DRAIN;
      else if (m_st == ST_DRAIN && valid_i[3:1] == 3'b000) m_st = ST_HALTED;
      else if (m_st == ST_HALTED && resume_i) m_st = ST_RUN;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] vld,
                      input logic br, input logic hlt, input logic res, input logic clr);
    apply(rst, req, vld, br, hlt, res, clr);
    tick();
  endtask

  initial begin
    rst_i = 1'b1; stall_req_i = '0; valid_i = '0; bra_i = 1'b0;
    halt_req_i = 1'b0; resume_i = 1'b0; perf_clr_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    apply(1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("rst_fetch_hold", 32'(fetch_hold_o), 32'h0);
    chk("rst_halted", 32'(halted_o), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'h0);
    tick();

    // Stall propagation patterns
    apply(0, 4'b1000, 4'b0000, 0, 0, 0, 0); chk("stall_1000", 32'(stall_o), 32'h7); tick();
    apply(0, 4'b0010, 4'b0000, 0, 0, 0, 0); chk("stall_0010", 32'(stall_o), 32'h1); tick();
    apply(0, 4'b0100, 4'b0000, 0, 0, 0, 0); chk("stall_0100", 32'(stall_o), 32'h7); tick();

    // Single branch pulse, no stalls
    step(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    apply(0, 4'b0000, 4'b0000, 1, 0, 0, 0); chk("br_kill_T", 32'(kill_o), 32'h7); tick();
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("br_kill_T1", 32'(kill_o), 32'h6);
    chk("br_kill_cnt", 32'(kill_cnt_o), 32'h1); tick();
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("br_kill_T2", 32'(kill_o), 32'h4); tick();
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("br_kill_T3", 32'(kill_o), 32'h0); tick();

    // Branch with history frozen by a writeback stall
    apply(0, 4'b0000, 4'b0000, 1, 0, 0, 0); chk("frz_T", 32'(kill_o[2]), 32'h1); tick();
    for (int i = 1; i <= 3; i++) begin
      apply(0, 4'b1000, 4'b0000, 0, 0, 0, 0); chk("frz_stalled", 32'(kill_o[2]), 32'h1); tick();
    end
    for (int i = 4; i <= 5; i++) begin
      apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("frz_after", 32'(kill_o[2]), 32'h1); tick();
    end
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("frz_drop", 32'(kill_o[2]), 32'h0); tick();

    // Halt, drain, resume
    apply(0, 4'b0000, 4'b1101, 0, 1, 0, 0); chk("halt_T_fh", 32'(fetch_hold_o), 32'h0); tick();
    apply(0, 4'b0000, 4'b1100, 0, 1, 0, 0); chk("halt_T1_fh", 32'(fetch_hold_o), 32'h1); tick();
    apply(0, 4'b0000, 4'b1100, 0, 1, 1, 0); chk("halt_T2_hl", 32'(halted_o), 32'h0); tick();
    apply(0, 4'b0000, 4'b0001, 0, 1, 0, 0); chk("halt_T3_hl", 32'(halted_o), 32'h0); tick();
    apply(0, 4'b0000, 4'b0000, 0, 1, 0, 0); chk("halt_T4_hl", 32'(halted_o), 32'h1); tick();
    apply(0, 4'b0000, 4'b0000, 0, 0, 1, 0); chk("halt_T5_hl", 32'(halted_o), 32'h1); tick();
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("resume_fh", 32'(fetch_hold_o), 32'h0);
    chk("resume_hl", 32'(halted_o), 32'h0); tick();

    // Resume while halt still requested re-enters drain
    step(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    apply(0, 4'b0000, 4'b0000, 0, 1, 1, 0); chk("rehalt_hl", 32'(halted_o), 32'h1); tick();
    apply(0, 4'b0000, 4'b0000, 0, 1, 0, 0); chk("rehalt_run", 32'(fetch_hold_o), 32'h0); tick();
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("rehalt_drain", 32'(fetch_hold_o), 32'h1); tick();
    step(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 0, 1, 0);

    // Counter saturation and clear
    step(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(0, 4'b1000, 4'b0000, 1, 0, 0, 0);
    apply(0, 4'b1000, 4'b0000, 1, 0, 0, 0);
    chk("sat_stall", 32'(stall_cnt_o), 32'd255);
    chk("sat_kill", 32'(kill_cnt_o), 32'd255); tick();
    step(0, 4'b1000, 4'b0000, 0, 0, 0, 1);
    apply(0, 4'b1000, 4'b0000, 0, 0, 0, 0); chk("clr_stall", 32'(stall_cnt_o), 32'h0);
    chk("clr_kill", 32'(kill_cnt_o), 32'h0); tick();
    apply(0, 4'b1000, 4'b0000, 0, 0, 0, 0); chk("clr_then_inc", 32'(stall_cnt_o), 32'h1); tick();

    // Reset while halted
    step(0, 4'b0000, 4'b0000, 1, 1, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0); chk("pre_rst_hl", 32'(halted_o), 32'h1); tick();
    step(1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    apply(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("post_rst_hl", 32'(halted_o), 32'h0);
    chk("post_rst_fh", 32'(fetch_hold_o), 32'h0);
    chk("post_rst_kcnt", 32'(kill_cnt_o), 32'h0); tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] rq, vl;
      rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      vl = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
      step($urandom_range(0, 99) == 0, rq, vl, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/urv_pipe_ctrl.md
URV_PIPE_CTRL -- requirements
Module: urv_pipe_ctrl

Interface
REQ-001 Parameter g_num_stages, default 4, pipeline stage count; stage 0 = fetch, stage g_num_stages-1 = writeback; legal 3..8.
REQ-002 Parameter g_branch_stage, default 2, index of the stage resolving branches; legal 1..g_num_stages-2.
REQ-003 Parameter g_self_stall_mask, default 4'b1010 (width g_num_stages), bit s=1: stage s handles its own stall request internally.
REQ-004 Parameter g_counter_width, default 32, width of the performance counters; legal 8..40.
REQ-005 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 stall_req_i  input  g_num_stages  per-stage stall request.
REQ-008 valid_i  input  g_num_stages  per-stage "holds valid instruction" flag.
REQ-009 bra_i  input  1  branch/jump taken, from stage g_branch_stage.
REQ-010 halt_req_i  input  1  level request to drain and halt the pipeline (debug entry).
REQ-011 resume_i  input  1  single-cycle pulse releasing the halt.
REQ-012 perf_clr_i  input  1  synchronous clear of both performance counters.
REQ-013 stall_o  output  g_num_stages  per-stage stall.
REQ-014 kill_o  output  g_num_stages  per-stage kill (invalidate).
REQ-015 fetch_hold_o  output  1  fetch must not issue new instructions.
REQ-016 halted_o  output  1  pipeline drained and halted.
REQ-017 stall_cnt_o  output  g_counter_width  cycles with stall_o[0]=1 while in RUN.
REQ-018 kill_cnt_o  output  g_counter_width  cycles with bra_i=1.

Function
REQ-019 stall_o[s] SHALL be combinational: OR of stall_req_i[j] for all j>s, OR'ed with stall_req_i[s] when g_self_stall_mask[s]=0.
REQ-020 stall_o[0] SHALL additionally OR in fetch_hold_o.
REQ-021 stall_o[g_num_stages-1] SHALL be constant 0 when its mask bit is 1.
REQ-022 A branch history register bh[0..g_branch_stage-1] SHALL shift (bh[0]<=bra_i, bh[k]<=bh[k-1]) only on cycles with stall_o[g_branch_stage]=0; it holds otherwise.
REQ-023 kill_o[s] for 1<=s<=g_branch_stage SHALL be bra_i OR bh[0..s-1]; kill_o[0] SHALL equal bra_i; kill_o[s] for s>g_branch_stage SHALL be 0.
REQ-024 FSM states RUN, DRAIN, HALTED; encoding free; fetch_hold_o=1 in DRAIN and HALTED, halted_o=1 only in HALTED; both outputs registered-state decodes.
REQ-025 RUN -> DRAIN on the cycle halt_req_i=1.
REQ-026 DRAIN -> HALTED on the cycle valid_i[g_num_stages-1:1]==0; if the condition holds on entry cycle +1 the transition completes in 2 cycles after halt_req_i.
REQ-027 HALTED -> RUN on resume_i=1 regardless of halt_req_i; if halt_req_i is still 1 in RUN, DRAIN is re-entered next cycle.
REQ-028 resume_i in RUN or DRAIN SHALL be ignored; halt_req_i deassertion in DRAIN SHALL NOT abort the drain.
REQ-029 Branches during DRAIN SHALL kill normally per REQ-023; kill logic is independent of FSM state.
REQ-030 stall_cnt_o SHALL increment by 1 per cycle with FSM=RUN and stall_o[0]=1; kill_cnt_o per cycle with bra_i=1.
REQ-031 Counters SHALL saturate at all-ones (no wrap).
REQ-032 perf_clr_i SHALL zero both counters and take priority over an increment in the same cycle.

Reset
REQ-033 On rst_i=1 at a clock edge: FSM=RUN, bh all 0, both counters 0; hence fetch_hold_o=0, halted_o=0, kill_o=bra_i-derived only.
REQ-034 Reset mid-DRAIN or in HALTED SHALL return to RUN in one cycle with no resume_i required.

Verification
REQ-035 Defaults; stall_req_i=4'b1000 -> stall_o=4'b0111; stall_req_i=4'b0010 -> stall_o=4'b0001; stall_req_i=4'b0100 -> stall_o=4'b0111.
REQ-036 Defaults, no stalls, bra_i pulse at cycle T -> kill_o[2] high T..T+2, kill_o[1] high T..T+1, kill_o[0] at T only, kill_o[3]=0; kill_cnt_o=1.
REQ-037 bra_i at T, stall_req_i[3]=1 for T+1..T+3 -> kill_o[2] stays high through T+5 (history frozen), then drops.
REQ-038 halt_req_i at T with valid_i[3:1]=3'b110 until T+2, then 0 -> fetch_hold_o=1 from T+1, halted_o=1 from T+4; resume_i pulse -> RUN next cycle, fetch_hold_o=0.
REQ-039 g_counter_width=8, stall_req_i[3]=1 for 300 cycles -> stall_cnt_o=255; perf_clr_i with continued stall -> 0 next cycle.
REQ-040 rst_i asserted while HALTED -> halted_o=0, fetch_hold_o=0, counters 0 after one edge.
